mul_sequencer: RTL

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_core.sv | 73 +++++++
 rtl/mul_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the M-extension multiply sequencer.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_MUL_LATENCY = 3;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;

endpackage

// File: rtl/mul_core.sv
// Pipelined 33x33 signed multiplier; operands captured on start, product
// stable MUL_LATENCY cycles after the capture cycle.
module mul_core
    import mul_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        a_signed,
    input  logic        b_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [31:0]        a_q, a_d, b_q, b_d;
    logic signed [32:0] a_ext, b_ext;
    logic signed [63:0] a_w, b_w;
    logic [63:0]        mul_w;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (start) begin
            a_d = a;
            b_d = b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // The 33rd bit is either the sign or zero, so one signed multiply covers s*s, s*u and u*u.
    always_comb begin
        a_ext = {a_signed & a_q[31], a_q};
        b_ext = {b_signed & b_q[31], b_q};
        a_w   = {{31{a_ext[32]}}, a_ext};
        b_w   = {{31{b_ext[32]}}, b_ext};
        mul_w = a_w * b_w;
    end

    if (MUL_LATENCY == 1) begin : g_comb
        assign product = mul_w;
    end else begin : g_pipe
        logic [63:0] prod_q [MUL_LATENCY-1];
        logic [63:0] prod_d [MUL_LATENCY-1];

        always_comb begin
            prod_d[0] = mul_w;
            for (int unsigned i = 1; i < MUL_LATENCY - 1; i++) begin
                prod_d[i] = prod_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < MUL_LATENCY - 1; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end

        assign product = prod_q[MUL_LATENCY-2];
    end

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multiply sequencer: stalls the front end while mul_core works and
// presents the selected 32-bit result for the EX-to-MEM transfer.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_mul,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_ex,
    input  logic        flush_E,
    input  logic        hold_M,
    output logic        stall_req,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        busy
);

    localparam int unsigned    CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [4:0]         rd_q, rd_d;
    logic               a_sgn_q, a_sgn_d;
    logic               b_sgn_q, b_sgn_d;
    logic [31:0]        result_q, result_d;
    logic [4:0]         rd_out_q, rd_out_d;
    logic               rvalid_q, rvalid_d;
    logic               accept;
    logic [63:0]        product;

    assign accept = (state_q == IDLE) && ex_valid && ex_is_mul && !funct3[2] && !flush_E;

    mul_core #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_core (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .a_signed (a_sgn_q),
        .b_signed (b_sgn_q),
        .a        (rs1_val),
        .b        (rs2_val),
        .product  (product)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        a_sgn_d  = a_sgn_q;
        b_sgn_d  = b_sgn_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        rvalid_d = rvalid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    f3_d    = funct3;
                    rd_d    = rd_ex;
                    a_sgn_d = (funct3 != MULHU);
                    b_sgn_d = (funct3 == MUL) || (funct3 == MULH);
                end
            end
            BUSY: begin
                if (flush_E) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = (f3_q == MUL) ? product[31:0] : product[63:32];
                    rd_out_d = rd_q;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (flush_E || !hold_M) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            a_sgn_q  <= 1'b0;
            b_sgn_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            a_sgn_q  <= a_sgn_d;
            b_sgn_q  <= b_sgn_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A flush in DONE must kill the transfer in the same cycle, hence the combinational mask.
    assign result_valid = rvalid_q && !flush_E;
    assign stall_req    = accept || (state_q == BUSY);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule
